// File: rtl/clk_ratio_detect.sv
// Measures the period of a clk-synchronous divided clock, locks on a stable ratio,
// and flags ratio changes and a stalled input. Define DUTY_CHECK_EN to add duty_err.
module clk_ratio_detect #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_in,
    output logic [CNT_W-1:0] ratio,
    output logic             locked,
    output logic             err,
`ifdef DUTY_CHECK_EN
    output logic             duty_err,
`endif
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LOCK_VAL = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ACQ, TRACK, LOCKED} state_t;

    state_t           state;
    logic             s0, s1;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ref_per;
    logic [CNT_W-1:0] match;
    logic             rise;

    assign rise = s0 & ~s1;

`ifdef DUTY_CHECK_EN
    logic [CNT_W-1:0] high_cnt;
    logic             fall;
    logic [CNT_W-1:0] half_lo, half_hi;

    assign fall    = s1 & ~s0;
    assign half_lo = ref_per >> 1;
    assign half_hi = half_lo + {{(CNT_W-1){1'b0}}, ref_per[0]};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            s0      <= 1'b0;
            s1      <= 1'b0;
            cnt     <= '0;
            ref_per <= '0;
            match   <= '0;
            ratio   <= '0;
            locked  <= 1'b0;
            err     <= 1'b0;
            timeout <= 1'b0;
`ifdef DUTY_CHECK_EN
            high_cnt <= '0;
            duty_err <= 1'b0;
`endif
        end else begin
            s0      <= div_in;
            s1      <= s0;
            err     <= 1'b0;
            timeout <= 1'b0;

            if (rise)
                cnt <= ONE;
            else if (cnt != CNT_MAX)
                cnt <= cnt + ONE;

            // On a rise, cnt holds the period just completed.
            case (state)
                IDLE: begin
                    if (rise)
                        state <= ACQ;
                end
                ACQ: begin
                    if (rise) begin
                        ref_per <= cnt;
                        match   <= '0;
                        state   <= TRACK;
                    end
                end
                TRACK: begin
                    if (rise) begin
                        if (cnt == ref_per) begin
                            match <= match + ONE;
                            if (match + ONE == LOCK_VAL) begin
                                state  <= LOCKED;
                                ratio  <= ref_per;
                                locked <= 1'b1;
                            end
                        end else begin
                            ref_per <= cnt;
                            match   <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (rise && cnt != ref_per) begin
                        err     <= 1'b1;
                        locked  <= 1'b0;
                        ratio   <= '0;
                        ref_per <= cnt;
                        match   <= '0;
                        state   <= TRACK;
                    end
                end
                default: state <= IDLE;
            endcase

            // A rise in the timeout cycle takes precedence, so this never overlaps err.
            if (state != IDLE && !rise && cnt == TO_VAL) begin
                timeout <= 1'b1;
                locked  <= 1'b0;
                ratio   <= '0;
                state   <= IDLE;
            end

`ifdef DUTY_CHECK_EN
            duty_err <= 1'b0;
            if (rise)
                high_cnt <= ONE;
            else if (s0 && high_cnt != CNT_MAX)
                high_cnt <= high_cnt + ONE;
            if (fall && state == LOCKED && high_cnt != half_lo && high_cnt != half_hi)
                duty_err <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_clk_ratio_detect.sv
// Randomized and directed stimulus for clk_ratio_detect, checked every cycle against
// a reference model built from rise times, period run lengths and high-run lengths.
module tb_clk_ratio_detect;

    localparam int LOCK_CNT = 3;
    localparam int TIMEOUT  = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       div_in;
    logic [7:0] ratio;
    logic       locked, err, timeout;
`ifdef DUTY_CHECK_EN
    logic       duty_err;
`endif

    clk_ratio_detect #(.CNT_W(8), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset   (reset),
        .div_in  (div_in),
        .ratio   (ratio),
        .locked  (locked),
        .err     (err),
`ifdef DUTY_CHECK_EN
        .duty_err(duty_err),
`endif
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: sampled-input history, rise bookkeeping and period run length.
    bit p1, p2;
    int last_rise, n_rise, ref_p, run, hi_run, m_ratio;
    bit m_locked, m_err, m_to, m_duty;

    task automatic check_eq(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic step(input bit d, input bit rst);
        bit rise, fall;
        int gap;
        div_in = d;
        reset  = rst;
        @(posedge clk);
        #1;
        cyc++;
        m_err = 0; m_to = 0; m_duty = 0;
        if (rst) begin
            n_rise = 0; m_locked = 0; m_ratio = 0;
            p1 = 0; p2 = 0; run = 0; hi_run = 0;
        end else begin
            rise = p1 && !p2;
            fall = !p1 && p2;
            gap  = cyc - last_rise;
            if (fall && m_locked && hi_run != ref_p / 2 && hi_run != (ref_p + 1) / 2)
                m_duty = 1;
            if (rise) begin
                if (n_rise == 0) begin
                    n_rise = 1;
                end else if (n_rise == 1) begin
                    n_rise = 2; ref_p = gap; run = 1;
                end else if (gap == ref_p) begin
                    run++;
                    if (!m_locked && run == LOCK_CNT + 1) begin
                        m_locked = 1; m_ratio = gap;
                    end
                end else begin
                    if (m_locked) begin
                        m_err = 1; m_locked = 0; m_ratio = 0;
                    end
                    ref_p = gap; run = 1;
                end
                last_rise = cyc;
            end else if (n_rise > 0 && gap == TIMEOUT) begin
                m_to = 1; m_locked = 0; m_ratio = 0; n_rise = 0;
            end
            if (d) hi_run = p1 ? hi_run + 1 : 1;
            p2 = p1;
            p1 = d;
        end
        check_eq("locked",  int'(locked),  int'(m_locked));
        check_eq("ratio",   int'(ratio),   m_ratio);
        check_eq("err",     int'(err),     int'(m_err));
        check_eq("timeout", int'(timeout), int'(m_to));
`ifdef DUTY_CHECK_EN
        check_eq("duty_err", int'(duty_err), int'(m_duty));
`endif
    endtask

    task automatic wave(input int p, input int h, input int n);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < p; k++)
                step(k < h, 1'b0);
    endtask

    task automatic idle_low(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0);
    endtask

    initial begin
        reset  = 1'b1;
        div_in = 1'b0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        // div2, div8, ratio change 4 -> 8, stall, reset while locked
        wave(2, 1, 10);
        check_eq("div2_ratio", int'(ratio), 2);
        wave(8, 4, 8);
        check_eq("div8_ratio", int'(ratio), 8);
        wave(4, 2, 8);
        wave(8, 4, 8);
        wave(4, 2, 8);
        idle_low(80);
        check_eq("stall_locked", int'(locked), 0);
        wave(4, 2, 8);
        step(1'b0, 1'b1);
        wave(4, 2, 8);

        // Boundary: period equal to TIMEOUT still locks, one longer times out
        idle_low(5);
        wave(TIMEOUT, 1, 6);
        check_eq("p64_ratio", int'(ratio), TIMEOUT);
        wave(TIMEOUT + 1, 1, 3);

`ifdef DUTY_CHECK_EN
        wave(8, 3, 8);
        wave(8, 4, 8);
        wave(7, 3, 8);
        wave(7, 4, 8);
        wave(7, 2, 4);
`endif

        for (int s = 0; s < 60; s++) begin
            int kind, p, h, n;
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                idle_low(int'($urandom_range(50, 90)));
            end else if (kind == 1) begin
                step(1'b0, 1'b1);
            end else if (kind == 2) begin
                n = int'($urandom_range(2, 8));
                for (int i = 0; i < n; i++) begin
                    p = int'($urandom_range(2, 6));
                    h = int'($urandom_range(1, p - 1));
                    wave(p, h, 1);
                end
            end else begin
                p = int'($urandom_range(2, 20));
                h = int'($urandom_range(1, p - 1));
                n = int'($urandom_range(1, 10));
                wave(p, h, n);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
